// File: rtl/su_config_loader.sv
// Serial configuration loader for a row of switch units: shifts a frame into a
// shadow register over a valid/ready handshake and commits it atomically to dir_con_bus.
module su_config_loader #(
    parameter int N_SU  = 4,
    parameter int CFG_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_clear,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_ready,
    output logic                   cfg_done,
    output logic                   cfg_abort,
    output logic                   busy,
    output logic [N_SU*CFG_W-1:0]  dir_con_bus
);

    localparam int FW = N_SU * CFG_W;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FW - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [FW-1:0] shadow;
    logic [FW-1:0] shadow_nxt;
    logic [FW-1:0] bus_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          done_nxt;
    logic          abort_nxt;
    logic          accept;

    // cfg_ready is a register that mirrors state == LOAD, so it can gate the handshake directly.
    assign accept = cfg_valid && cfg_ready;

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        count_nxt  = count;
        bus_nxt    = dir_con_bus;
        done_nxt   = 1'b0;
        abort_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt  = S_LOAD;
                    shadow_nxt = '0;
                    count_nxt  = '0;
                end else if (cfg_clear) begin
                    bus_nxt = '0;
                end
            end
            S_LOAD: begin
                // A restart drops the partial frame, including any bit offered alongside it.
                if (cfg_start) begin
                    shadow_nxt = '0;
                    count_nxt  = '0;
                    abort_nxt  = 1'b1;
                end else if (accept) begin
                    shadow_nxt = {shadow[FW-2:0], cfg_bit};
                    count_nxt  = count + CW'(1);
                    if (count == LAST_IDX) begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                bus_nxt   = shadow;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are derived from the next state so they line up with it after the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shadow      <= '0;
            count       <= '0;
            dir_con_bus <= '0;
            cfg_ready   <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_abort   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            count       <= count_nxt;
            dir_con_bus <= bus_nxt;
            cfg_ready   <= (state_nxt == S_LOAD);
            cfg_done    <= done_nxt;
            cfg_abort   <= abort_nxt;
            busy        <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: doc/su_config_loader.md
Name: su_config_loader

Overview:
- Serial configuration writer for a row of switch units (SUs).
- Each SU is steered by a 6-bit direction-control word: bit0 top-left, bit1 top-right, bit2 left-bottom, bit3 right-bottom, bit4 top-bottom, bit5 left-right pass-gate enables.
- Accepts a bitstream over a valid/ready handshake into a shadow shift register, then commits it atomically to the live dir_con bus. The routing fabric therefore never sees a partially loaded configuration.
- Sits between the configuration controller and the SU array.

Parameters:
- N_SU, 4, number of switch units driven.
- CFG_W, 6, control bits per SU. Fixed by the SU interface; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  one-cycle pulse that begins a new frame.
- cfg_clear  input  1  one-cycle pulse that opens all switches (live bus to 0).
- cfg_valid  input  1  cfg_bit is valid.
- cfg_bit  input  1  serial configuration bit, MSB of the frame first.
- cfg_ready  output  1  loader accepts a bit this cycle.
- cfg_done  output  1  one-cycle pulse: new configuration is live.
- cfg_abort  output  1  one-cycle pulse: partial frame discarded.
- busy  output  1  high in LOAD or COMMIT.
- dir_con_bus  output  N_SU*CFG_W  live control words; SU i uses bits [i*CFG_W +: CFG_W].

Behaviour:
- Definitions: FW = N_SU*CFG_W. Bit counter width = clog2(FW+1). Shadow register is FW bits.
- Reset (async, immediate): state IDLE, shadow = 0, count = 0, dir_con_bus = 0 (all switches open), cfg_ready = 0, cfg_done = 0, cfg_abort = 0, busy = 0.
- All outputs are registered. cfg_ready = (state == LOAD). busy = (state != IDLE).

State IDLE:
- cfg_start -> LOAD, count = 0, shadow = 0.
- Otherwise cfg_clear -> dir_con_bus = 0 on the next edge.
- cfg_valid is ignored; no handshake occurs.

State LOAD:
- Each edge with cfg_valid && cfg_ready: shadow = {shadow[FW-2:0], cfg_bit}, count++.
- The first accepted bit lands in the MSB of dir_con_bus (SU N_SU-1, bit 5).
- On the edge that accepts bit number FW: -> COMMIT. cfg_ready drops in the following cycle, so no bit FW+1 is ever accepted.
- cfg_valid low: hold; no timeout.
- cfg_start in LOAD: discard the partial frame, shadow = 0, count = 0, stay in LOAD, cfg_abort high for exactly one cycle. A bit offered in the same cycle as cfg_start is discarded, not counted.
- cfg_clear in LOAD: ignored. dir_con_bus is untouched throughout LOAD.

State COMMIT (exactly one cycle):
- dir_con_bus = shadow on the exiting edge, and cfg_done is high in the cycle after that edge, aligned with the new bus value.
- -> IDLE. cfg_start and cfg_clear arriving in COMMIT are ignored.

Timing and corner cases:
- Latency: last bit accepted at edge k; dir_con_bus updates at edge k+1; cfg_done is high between edges k+1 and k+2.
- Back-to-back frames: cfg_start may be asserted in the first IDLE cycle after COMMIT.
- cfg_start and cfg_clear together in IDLE: cfg_start wins, live bus unchanged.
- Reset mid-LOAD or mid-COMMIT: live bus goes to 0 immediately and the partial frame is lost.

Test Plan:
- Reset and basic load (N_SU=2, FW=12):
  - Stimulus: assert rst mid-run, release; pulse cfg_start; stream 12'hA5C MSB-first with cfg_valid held high.
  - Response: during reset, dir_con_bus = 0 and cfg_ready = 0 asynchronously. cfg_ready is high for 12 cycles. dir_con_bus = 12'hA5C one edge after the 12th bit, with SU1 = 6'b101001 and SU0 = 6'b011100. One cfg_done pulse.
- Stalled stream:
  - Stimulus: stream 12'h3F0 with cfg_valid low for 3 cycles after bits 4 and 9.
  - Response: bus stays at its old value until commit, then becomes 12'h3F0. Exactly 12 handshakes counted.
- Abort:
  - Stimulus: after 7 bits of 12'hFFF, pulse cfg_start, then send 12'h001.
  - Response: cfg_abort pulses once. Final bus = 12'h001, with no ones leaking from the aborted frame.
- Overrun guard:
  - Stimulus: keep cfg_valid high for 15 cycles with cfg_bit = 1.
  - Response: only 12 bits accepted. Bus = 12'hFFF. cfg_ready low from the cycle after the 12th bit.
- Clear versus start:
  - Stimulus: with bus = 12'hA5C, pulse cfg_clear in IDLE; later pulse cfg_start and cfg_clear together.
  - Response: cfg_clear alone gives bus = 0 next edge. Simultaneous pulses give LOAD entered with the bus unchanged.
- Reset during COMMIT:
  - Stimulus: assert rst in the COMMIT cycle.
  - Response: bus = 0, no cfg_done, state IDLE.
